// File: rtl/armleo_wrr_arbiter.sv
// Weighted round-robin arbiter: each requestor may win up to its weight in
// consecutive packets, and the grant is held on the owner for a whole multi-beat packet.
//
// state  | meaning
// IDLE   | grant follows the rotating-priority scan of request
// LOCKED | grant held on owner until its last beat is accepted
module armleo_wrr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          request,
    input  logic [WIDTH*WEIGHT_W-1:0] weight,
    input  logic                      ready,
    input  logic                      last,
    output logic [WIDTH-1:0]          grant,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      grant_valid
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [WEIGHT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0]    owner, owner_nxt;

    logic [IDX_W-1:0]    g;
    logic                found;
    logic [IDX_W:0]      idx_wide;
    logic [IDX_W-1:0]    c;
    logic [WEIGHT_W:0]   w_eff;
    logic [WEIGHT_W:0]   base;
    logic [WEIGHT_W:0]   base_inc;

    // Scan from the farthest offset down so the nearest requesting index wins.
    always_comb begin
        g        = '0;
        found    = 1'b0;
        idx_wide = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            idx_wide = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (idx_wide >= (IDX_W + 1)'(WIDTH))
                idx_wide = idx_wide - (IDX_W + 1)'(WIDTH);
            if (request[idx_wide[IDX_W-1:0]]) begin
                g     = idx_wide[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (rst_n) begin
            if (state == LOCKED) begin
                grant_idx   = owner;
                grant_valid = 1'b1;
            end else if (found) begin
                grant_idx   = g;
                grant_valid = 1'b1;
            end
        end
        if (grant_valid)
            grant[grant_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        owner_nxt = owner;

        c     = (state == LOCKED) ? owner : g;
        w_eff = {1'b0, weight[c*WEIGHT_W +: WEIGHT_W]};
        if (w_eff == '0)
            w_eff = (WEIGHT_W + 1)'(1);
        // The quota count only carries over when the current pointer owner wins again.
        base     = (c == ptr) ? {1'b0, cnt} : '0;
        base_inc = base + (WEIGHT_W + 1)'(1);

        if (grant_valid && ready) begin
            if (!last) begin
                if (state == IDLE) begin
                    state_nxt = LOCKED;
                    owner_nxt = g;
                end
            end else begin
                state_nxt = IDLE;
                if (base_inc < w_eff) begin
                    ptr_nxt = c;
                    cnt_nxt = base_inc[WEIGHT_W-1:0];
                end else begin
                    ptr_nxt = (c == IDX_W'(WIDTH - 1)) ? '0 : c + IDX_W'(1);
                    cnt_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
        end
    end

endmodule

// File: doc/armleo_wrr_arbiter.md
# armleo_wrr_arbiter

Parametrised weighted round-robin arbiter with packet locking and a valid/ready handshake toward a shared downstream resource such as a bus master port or memory port. Each requestor may win up to `weight` consecutive packets before priority rotates. The grant stays locked to the owner from the first accepted beat to the last accepted beat of a multi-beat packet. It sits in front of shared interconnect resources and is the successor to the plain single-cycle round robin.

## Interface
- `WIDTH`, 4: number of requestors; legal range 2..32.
- `WEIGHT_W`, 4: bit width of each per-requestor weight field.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `request`  in  WIDTH  per-requestor request; bit i high means requestor i has a beat pending.
- `weight`  in  WIDTH*WEIGHT_W  field i at `[i*WEIGHT_W +: WEIGHT_W]` is the packet quota for requestor i; value 0 is treated as 1. Quasi-static.
- `ready`  in  1  downstream accepts the granted beat this cycle.
- `last`  in  1  the granted beat is the final beat of its packet; qualified by `grant_valid && ready`.
- `grant`  out  WIDTH  one-hot grant, or all zeros.
- `grant_idx`  out  $clog2(WIDTH)  binary index of the granted requestor; 0 when `grant_valid` is low.
- `grant_valid`  out  1  high when `grant` is non-zero.

## Operation
- State registers:
  - `state` ∈ {IDLE, LOCKED}.
  - `ptr`: the highest-priority index.
  - `cnt` (WEIGHT_W bits): packets already completed by `ptr` in its current turn.
  - `owner`: index, valid only in LOCKED.
- Effective weight: `w[i] = (weight field i == 0) ? 1 : weight field i`.
- IDLE grant:
  - `g` is the first index with `request` set, scanning `ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1`.
  - `grant = 1<<g` and `grant_valid = 1` when `request != 0`; otherwise `grant = 0`.
- LOCKED grant:
  - `grant = 1<<owner` and `grant_valid = 1` regardless of `request`.
  - Requestors must hold `request` until their last beat. A drop mid-packet is ignored.
- Beat accepted (`grant_valid && ready`) with `last=0` in IDLE: go to LOCKED, `owner <= g`. `ptr` and `cnt` are unchanged.
- Beat accepted with `last=0` in LOCKED: no state change.
- Packet completion is an accepted beat with `last=1`, in either state. With completing index `c` (`g` in IDLE, `owner` in LOCKED):
  - `base = (c == ptr) ? cnt : 0`.
  - If `base + 1 < w[c]`: `ptr <= c`, `cnt <= base + 1`.
  - Else: `ptr <= (c + 1) % WIDTH`, `cnt <= 0`.
  - `state <= IDLE`.
- A single-beat packet (`last=1` on the first accepted beat in IDLE) never enters LOCKED.
- `cnt` comparison is performed at WEIGHT_W+1 bits so that `base + 1` cannot overflow.
- Reset:
  - Sets `ptr = 0`, `cnt = 0`, `state = IDLE`, `owner = 0`.
  - While `rst_n` is low, `grant`, `grant_idx` and `grant_valid` are forced to 0.
  - Reset mid-packet abandons the lock with no completion update.
- No state changes when `grant_valid && ready` is false; `last` without acceptance is ignored.

## Timing
- `request` → `grant`/`grant_idx`/`grant_valid` is combinational in IDLE: zero-cycle latency from request to grant.
- `ready` and `last` have no combinational path to any output; they affect only next-cycle state.
- After a completion at edge N, the new winner is visible in cycle N+1. Back-to-back packets from different requestors are possible with no idle cycle.
- Lock takes effect in the cycle after the first accepted non-last beat. The grant in that first cycle already equals `owner` because `g` is stable while `ready` is pending.
- Steady-state throughput is one beat per cycle when `ready` is held high.

## Test plan
- Fairness: WIDTH=4, all weights 1, `request=4'b1111`, `ready=1`, `last=1` every cycle → `grant` sequence `0001, 0010, 0100, 1000, 0001`; `grant_idx` sequence 0,1,2,3,0.
- Weighting: `weight[1]=3`, others 1, `request=4'b0011`, single-beat packets → grant sequence `0001, 0010, 0010, 0010, 0001, 0010` …
- Lock hold: `request=4'b0101`; requestor 0 sends 4 beats (`last` on beat 4) while `ready` toggles 1,0,1,1,1. Requestor 0 drops `request` after beat 2 → `grant=0001` held until beat 4 is accepted, then `grant=0100` next cycle.
- Weight 0 and skip: `weight[2]=0`, `request=4'b0100`, then `4'b1100` → behaves as weight 1; the grant moves 2→3 after one packet.
- Idle and no accept: `request=0` → `grant=0`, `grant_idx=0`, `grant_valid=0`. `request=4'b1000` with `ready=0` for 5 cycles → `grant=1000` steady and `ptr` unchanged.
- Reset mid-packet: requestor 1 locked after 2 beats, `rst_n=0` for one cycle → outputs 0 during reset. Afterwards `request=4'b1111` → `grant=0001` (ptr=0, IDLE).
